// File: rtl/qmax_table_rmw_pkg.sv
// Shared definitions for the Q-table blocks: FSM encoding, update modes and
// the default geometry used by the table, its bus interface and helpers.
package qtable_pkg;

    localparam int QT_ADDR_WIDTH = 6;
    localparam int QT_DATA_WIDTH = 32;
    localparam int QT_DEPTH      = 64;
    localparam int QT_NUM_RD     = 2;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } qt_state_e;

    localparam logic UPD_OVERWRITE = 1'b0;
    localparam logic UPD_MAX       = 1'b1;

endpackage

// File: rtl/qmax_table_rmw_if.sv
// Bus bundle of the Q-max table: clear/ready, read ports and update port.
// The master drives requests, the table (slave) drives responses.
interface qmax_table_rmw_if
    import qtable_pkg::*;
#(
    parameter int ADDR_WIDTH = QT_ADDR_WIDTH,
    parameter int DATA_WIDTH = QT_DATA_WIDTH,
    parameter int NUM_RD     = QT_NUM_RD
) ();

    logic                         i_clear;
    logic                         o_ready;
    logic [NUM_RD-1:0]            i_rd_en;
    logic [NUM_RD*ADDR_WIDTH-1:0] i_rd_addr;
    logic [NUM_RD*DATA_WIDTH-1:0] o_rd_data;
    logic [NUM_RD-1:0]            o_rd_valid;
    logic                         i_upd_valid;
    logic                         i_upd_mode;
    logic [ADDR_WIDTH-1:0]        i_upd_addr;
    logic [DATA_WIDTH-1:0]        i_upd_data;
    logic                         o_upd_done;
    logic [DATA_WIDTH-1:0]        o_upd_value;
    logic                         o_upd_changed;

    modport master (
        output i_clear, i_rd_en, i_rd_addr, i_upd_valid, i_upd_mode, i_upd_addr, i_upd_data,
        input  o_ready, o_rd_data, o_rd_valid, o_upd_done, o_upd_value, o_upd_changed
    );

    modport slave (
        input  i_clear, i_rd_en, i_rd_addr, i_upd_valid, i_upd_mode, i_upd_addr, i_upd_data,
        output o_ready, o_rd_data, o_rd_valid, o_upd_done, o_upd_value, o_upd_changed
    );

endinterface

// File: rtl/qmax_table_rmw_cmp.sv
// Combinational update resolver: overwrite or full-width signed max of the
// candidate against the stored value, plus a flag telling whether it changed.
module qmax_cmp
    import qtable_pkg::*;
#(
    parameter int DATA_WIDTH = QT_DATA_WIDTH
) (
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] old_value,
    input  logic [DATA_WIDTH-1:0] cand_value,
    output logic [DATA_WIDTH-1:0] new_value,
    output logic                  changed
);

    // Resolve the value to store; ties in max mode keep the old entry.
    always_comb begin
        new_value = old_value;
        if (mode == UPD_OVERWRITE) begin
            new_value = cand_value;
        end else if ($signed(cand_value) > $signed(old_value)) begin
            new_value = cand_value;
        end else begin
            new_value = old_value;
        end
        changed = (new_value != old_value);
    end

endmodule

// File: rtl/qmax_table_rmw.sv
// Multi-read-port per-state Q-max table with a read-modify-write update
// stage, change reporting and a counter-driven clear sweep.
module qmax_table_rmw
    import qtable_pkg::*;
#(
    parameter int ADDR_WIDTH = QT_ADDR_WIDTH,
    parameter int DATA_WIDTH = QT_DATA_WIDTH,
    parameter int DEPTH      = QT_DEPTH,
    parameter int NUM_RD     = QT_NUM_RD
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    qmax_table_rmw_if.slave bus
);

    localparam int                    CW       = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
        return ({1'b0, addr} < CW'(DEPTH));
    endfunction

    logic [DATA_WIDTH-1:0]        mem_r [DEPTH];
    qt_state_e                    state_r;
    logic [ADDR_WIDTH-1:0]        cnt_r;

    logic                         s1_valid_r;
    logic                         s1_mode_r;
    logic [ADDR_WIDTH-1:0]        s1_addr_r;
    logic [DATA_WIDTH-1:0]        s1_data_r;

    logic                         ready_r;
    logic [NUM_RD-1:0]            rd_valid_r;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data_r;
    logic                         upd_done_r;
    logic [DATA_WIDTH-1:0]        upd_value_r;
    logic                         upd_changed_r;

    logic                         accept_s;
    logic                         s1_in_range_s;
    logic                         s1_write_s;
    logic [DATA_WIDTH-1:0]        old_value_s;
    logic [DATA_WIDTH-1:0]        new_value_s;
    logic                         changed_s;
    logic [ADDR_WIDTH-1:0]        rd_addr_s [NUM_RD];
    logic [DATA_WIDTH-1:0]        rd_word_s [NUM_RD];

    qmax_cmp #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cmp (
        .mode       (s1_mode_r),
        .old_value  (old_value_s),
        .cand_value (s1_data_r),
        .new_value  (new_value_s),
        .changed    (changed_s)
    );

    // Update acceptance and the S1 read of the entry being modified.
    always_comb begin
        accept_s      = 1'b0;
        s1_in_range_s = addr_in_range(s1_addr_r);
        old_value_s   = '0;
        if (state_r == ST_READY) begin
            accept_s = bus.i_upd_valid && !bus.i_clear;
        end else begin
            accept_s = 1'b0;
        end
        if (s1_in_range_s) begin
            old_value_s = mem_r[s1_addr_r];
        end else begin
            old_value_s = '0;
        end
        s1_write_s = s1_valid_r && s1_in_range_s;
    end

    // Per-port read mux; addresses beyond the table read as zero.
    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            rd_addr_s[k] = bus.i_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            rd_word_s[k] = '0;
            if (addr_in_range(rd_addr_s[k])) begin
                rd_word_s[k] = mem_r[rd_addr_s[k]];
            end else begin
                rd_word_s[k] = '0;
            end
        end
    end

    // Storage: sweep writes zeros, otherwise S1 commits; untouched while in reset.
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            if (state_r == ST_CLEAR) begin
                mem_r[cnt_r] <= '0;
            end else if (s1_write_s) begin
                mem_r[s1_addr_r] <= new_value_s;
            end
        end
    end

    // Control FSM, update pipeline and all registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r       <= ST_CLEAR;
            cnt_r         <= '0;
            s1_valid_r    <= 1'b0;
            s1_mode_r     <= UPD_OVERWRITE;
            s1_addr_r     <= '0;
            s1_data_r     <= '0;
            ready_r       <= 1'b0;
            rd_valid_r    <= '0;
            rd_data_r     <= '0;
            upd_done_r    <= 1'b0;
            upd_value_r   <= '0;
            upd_changed_r <= 1'b0;
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_mode_r <= bus.i_upd_mode;
                s1_addr_r <= bus.i_upd_addr;
                s1_data_r <= bus.i_upd_data;
            end

            // An out-of-range update still reports completion, as a no-op.
            upd_done_r <= s1_valid_r;
            if (s1_valid_r) begin
                upd_value_r   <= s1_in_range_s ? new_value_s : '0;
                upd_changed_r <= s1_in_range_s && changed_s;
            end

            case (state_r)
                ST_CLEAR: begin
                    rd_valid_r <= '0;
                    if (cnt_r == LAST_IDX) begin
                        state_r <= ST_READY;
                        ready_r <= 1'b1;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                ST_READY: begin
                    for (int k = 0; k < NUM_RD; k++) begin
                        rd_valid_r[k] <= bus.i_rd_en[k];
                        if (bus.i_rd_en[k]) begin
                            rd_data_r[k*DATA_WIDTH +: DATA_WIDTH] <= rd_word_s[k];
                        end
                    end
                    if (bus.i_clear) begin
                        state_r <= ST_CLEAR;
                        cnt_r   <= '0;
                        ready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_CLEAR;
                    cnt_r      <= '0;
                    ready_r    <= 1'b0;
                    rd_valid_r <= '0;
                end
            endcase
        end
    end

    assign bus.o_ready       = ready_r;
    assign bus.o_rd_data     = rd_data_r;
    assign bus.o_rd_valid    = rd_valid_r;
    assign bus.o_upd_done    = upd_done_r;
    assign bus.o_upd_value   = upd_value_r;
    assign bus.o_upd_changed = upd_changed_r;

endmodule
